// File: rtl/mcu_branch_resolve_queue.sv
// In-order queue of conditional-branch predictions awaiting resolution from execute.
// Resolution drives BHT training, fetch redirect on mispredict and a saturating mispredict count.
module mcu_branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic                     push_pred_taken,
  input  logic [31:0]              push_pred_target,
  input  logic                     res_valid,
  input  logic [31:0]              res_pc,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  input  logic                     flush_in,
  output logic                     update_valid,
  output logic [31:0]              update_pc,
  output logic                     update_taken,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     res_error,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [31:0]      r_pc_mem  [DEPTH];
  logic             r_pt_mem  [DEPTH];
  logic [31:0]      r_tgt_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  logic             r_upd_valid_p1;
  logic [31:0]      r_upd_pc_p1;
  logic             r_upd_taken_p1;
  logic             r_redir_valid_p1;
  logic [31:0]      r_redir_pc_p1;
  logic             r_err_p1;
  logic [CNT_W-1:0] r_mis_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_res;
  logic [31:0]      w_head_pc;
  logic             w_head_pt;
  logic [31:0]      w_head_tgt;
  logic             w_pc_match;
  logic             w_res_ok;
  logic             w_err;
  logic             w_pop;
  logic             w_mis;
  logic             w_clear;
  logic [31:0]      w_redir_pc;

  // Flush masks both sides; a pc mismatch or empty queue is a protocol error, not a resolve.
  always_comb begin
    w_full     = (r_occ == OCC_W'(DEPTH));
    w_empty    = (r_occ == '0);
    w_push     = push_valid && !w_full && !flush_in;
    w_res      = res_valid && !flush_in;
    w_head_pc  = r_pc_mem[r_rd_ptr];
    w_head_pt  = r_pt_mem[r_rd_ptr];
    w_head_tgt = r_tgt_mem[r_rd_ptr];
    w_pc_match = (w_head_pc == res_pc);
    w_res_ok   = w_res && !w_empty && w_pc_match;
    w_err      = w_res && (w_empty || !w_pc_match);
    w_pop      = w_res && !w_empty;
    w_mis      = w_res_ok && ((res_taken != w_head_pt) ||
                              (res_taken && (res_target != w_head_tgt)));
    w_clear    = flush_in || w_mis;
    w_redir_pc = res_taken ? res_target : (w_head_pc + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_mis) begin
      r_pc_mem[r_wr_ptr]  <= push_pc;
      r_pt_mem[r_wr_ptr]  <= push_pred_taken;
      r_tgt_mem[r_wr_ptr] <= push_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  // ---- resolve -> registered training / redirect outputs (stage p1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_valid_p1   <= 1'b0;
      r_upd_pc_p1      <= '0;
      r_upd_taken_p1   <= 1'b0;
      r_redir_valid_p1 <= 1'b0;
      r_redir_pc_p1    <= '0;
      r_err_p1         <= 1'b0;
      r_mis_cnt        <= '0;
    end else begin
      r_upd_valid_p1   <= w_res_ok;
      r_redir_valid_p1 <= w_mis;
      r_err_p1         <= w_err;
      if (w_res_ok) begin
        r_upd_pc_p1    <= w_head_pc;
        r_upd_taken_p1 <= res_taken;
      end
      if (w_mis) r_redir_pc_p1 <= w_redir_pc;
      if (w_mis && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign push_ready     = !w_full;
  assign occupancy      = r_occ;
  assign update_valid   = r_upd_valid_p1;
  assign update_pc      = r_upd_pc_p1;
  assign update_taken   = r_upd_taken_p1;
  assign redirect_valid = r_redir_valid_p1;
  assign redirect_pc    = r_redir_pc_p1;
  assign res_error      = r_err_p1;
  assign mispredict_cnt = r_mis_cnt;

endmodule
